// File: rtl/jx2_mem_arb2_pkg.sv
// Shared definitions for the two-port memory arbiter: OK codes, OPM idle value,
// arbiter state encodings and the grant-history type.
package jx2_mem_arb2_pkg;

  localparam logic [1:0] UMEM_OK_READY = 2'b00;
  localparam logic [1:0] UMEM_OK_OK    = 2'b01;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;
  localparam logic [1:0] UMEM_OK_FAULT = 2'b11;

  localparam logic [4:0] JX2_OPM_IDLE  = 5'b00000;

  typedef enum logic [1:0] {
    JX2_ARB_IDLE  = 2'd0,
    JX2_ARB_GNT_A = 2'd1,
    JX2_ARB_GNT_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_LAST_A = 1'b0,
    ARB_LAST_B = 1'b1
  } arb_last_t;

  // Response seen by a port that does not currently own the memory bus.
  function automatic logic [1:0] waitResp(input logic [4:0] opm);
    return (opm != JX2_OPM_IDLE) ? UMEM_OK_HOLD : UMEM_OK_READY;
  endfunction

endpackage

// File: rtl/jx2_mem_arb2_rrpick.sv
// Combinational 2-way round-robin picker: a lone requester always wins, and on
// a tie the requester that was not granted last wins.
module jx2_mem_arb_rrpick
  import jx2_mem_arb2_pkg::*;
(
  input  logic      i_reqA,
  input  logic      i_reqB,
  input  arb_last_t i_lastGrant,
  output logic      o_grantA,
  output logic      o_grantB
);

  logic w_tie;

  assign w_tie    = i_reqA && i_reqB;
  assign o_grantA = i_reqA && (!w_tie || (i_lastGrant == ARB_LAST_B));
  assign o_grantB = i_reqB && (!w_tie || (i_lastGrant == ARB_LAST_A));

endmodule

// File: rtl/jx2_mem_arb2.sv
// Two-requester round-robin arbiter for the shared 128-bit memory port.
// Optional watchdog fault enabled by defining JX2_MEMARB_TIMEOUT_EN.
module jx2_mem_arb2
  import jx2_mem_arb2_pkg::*;
#(
  parameter int ADDR_W      = 48,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = 1024
)(
  input  logic              clock,
  input  logic              reset,

  input  logic [ADDR_W-1:0] reqAAddr,
  input  logic [DATA_W-1:0] reqADataI,
  input  logic [4:0]        reqAOpm,
  output logic [DATA_W-1:0] reqADataO,
  output logic [1:0]        reqAOK,

  input  logic [ADDR_W-1:0] reqBAddr,
  input  logic [DATA_W-1:0] reqBDataI,
  input  logic [4:0]        reqBOpm,
  output logic [DATA_W-1:0] reqBDataO,
  output logic [1:0]        reqBOK,

  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataO,
  output logic [4:0]        memOpm,
  input  logic [DATA_W-1:0] memDataI,
  input  logic [1:0]        memOK,

  output logic [1:0]        arbGrant
);

  arb_state_t        r_state;
  arb_state_t        w_nextState;
  arb_last_t         r_lastGrant;
  arb_last_t         w_nextLast;

  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memData;
  logic [4:0]        r_memOpm;
  logic [ADDR_W-1:0] w_nextAddr;
  logic [DATA_W-1:0] w_nextData;
  logic [4:0]        w_nextOpm;

  logic              w_reqA;
  logic              w_reqB;
  logic              w_grantA;
  logic              w_grantB;
  logic              w_timeout;

  assign w_reqA = (reqAOpm != JX2_OPM_IDLE);
  assign w_reqB = (reqBOpm != JX2_OPM_IDLE);

  jx2_mem_arb_rrpick u_rrpick (
    .i_reqA      (w_reqA),
    .i_reqB      (w_reqB),
    .i_lastGrant (r_lastGrant),
    .o_grantA    (w_grantA),
    .o_grantB    (w_grantB)
  );

`ifdef JX2_MEMARB_TIMEOUT_EN
  // Watchdog: reset on every grant and every OK, saturates instead of wrapping.
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYC);

  logic [15:0] r_toCount;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_toCount <= 16'd0;
    end else if ((r_state == JX2_ARB_IDLE) || (memOK == UMEM_OK_OK)) begin
      r_toCount <= 16'd0;
    end else if (r_toCount != 16'hFFFF) begin
      r_toCount <= r_toCount + 16'd1;
    end
  end

  assign w_timeout = (r_state != JX2_ARB_IDLE) && (r_toCount == TimeoutLimit);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= JX2_ARB_IDLE;
      r_lastGrant <= ARB_LAST_B;
      r_memAddr   <= '0;
      r_memData   <= '0;
      r_memOpm    <= JX2_OPM_IDLE;
    end else begin
      r_state     <= w_nextState;
      r_lastGrant <= w_nextLast;
      r_memAddr   <= w_nextAddr;
      r_memData   <= w_nextData;
      r_memOpm    <= w_nextOpm;
    end
  end

  // While granted, the owner's request is re-registered every edge so that
  // back-to-back operations (writeback then fill) need no re-arbitration.
  always_comb begin
    w_nextState = r_state;
    w_nextLast  = r_lastGrant;
    w_nextAddr  = r_memAddr;
    w_nextData  = r_memData;
    w_nextOpm   = r_memOpm;

    unique case (r_state)
      JX2_ARB_IDLE: begin
        w_nextOpm = JX2_OPM_IDLE;
        if (w_grantA) begin
          w_nextState = JX2_ARB_GNT_A;
          w_nextLast  = ARB_LAST_A;
          w_nextAddr  = reqAAddr;
          w_nextData  = reqADataI;
          w_nextOpm   = reqAOpm;
        end else if (w_grantB) begin
          w_nextState = JX2_ARB_GNT_B;
          w_nextLast  = ARB_LAST_B;
          w_nextAddr  = reqBAddr;
          w_nextData  = reqBDataI;
          w_nextOpm   = reqBOpm;
        end
      end

      JX2_ARB_GNT_A: begin
        if (w_timeout || (!w_reqA && (memOK == UMEM_OK_READY))) begin
          w_nextState = JX2_ARB_IDLE;
          w_nextOpm   = JX2_OPM_IDLE;
        end else begin
          w_nextAddr  = reqAAddr;
          w_nextData  = reqADataI;
          w_nextOpm   = reqAOpm;
        end
      end

      JX2_ARB_GNT_B: begin
        if (w_timeout || (!w_reqB && (memOK == UMEM_OK_READY))) begin
          w_nextState = JX2_ARB_IDLE;
          w_nextOpm   = JX2_OPM_IDLE;
        end else begin
          w_nextAddr  = reqBAddr;
          w_nextData  = reqBDataI;
          w_nextOpm   = reqBOpm;
        end
      end

      default: begin
        w_nextState = JX2_ARB_IDLE;
        w_nextOpm   = JX2_OPM_IDLE;
      end
    endcase
  end

  // The owner sees memOK directly (or an internal FAULT on timeout); anyone
  // else with a live request is told to HOLD.
  always_comb begin
    reqAOK   = waitResp(reqAOpm);
    reqBOK   = waitResp(reqBOpm);
    arbGrant = 2'b00;

    unique case (r_state)
      JX2_ARB_GNT_A: begin
        reqAOK   = w_timeout ? UMEM_OK_FAULT : memOK;
        arbGrant = 2'b01;
      end
      JX2_ARB_GNT_B: begin
        reqBOK   = w_timeout ? UMEM_OK_FAULT : memOK;
        arbGrant = 2'b10;
      end
      default: begin
        arbGrant = 2'b00;
      end
    endcase
  end

  assign reqADataO = memDataI;
  assign reqBDataO = memDataI;

  assign memAddr   = r_memAddr;
  assign memDataO  = r_memData;
  assign memOpm    = r_memOpm;

endmodule
